// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 3;
  localparam int MC_CW_DEF  = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    RUN,
    MC_BUSY,
    MC_DRAIN,
    HALTED
  } ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic flush_if_id;
    logic bubble_ex;
    logic bubble_mem;
  } stage_en_t;

  function automatic stage_en_t en_all();
    stage_en_t e;
    e = '0;
    e.pc_en     = 1'b1;
    e.en_if_id  = 1'b1;
    e.en_id_ex  = 1'b1;
    e.en_ex_mem = 1'b1;
    e.en_mem_wb = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs from the pipeline and stage-register controls back to it.
interface pipeline_stall_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MC_CW  = MC_CW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_valid;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic              mc_start;
  logic [MC_CW-1:0]  mc_cycles;
  logic              branch_taken;
  logic              mem_busy;
  logic              halt;

  logic              pc_en;
  logic              en_if_id;
  logic              en_id_ex;
  logic              en_ex_mem;
  logic              en_mem_wb;
  logic              flush_if_id;
  logic              bubble_ex;
  logic              bubble_mem;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_rd,
           mc_start, mc_cycles, branch_taken, mem_busy, halt,
    input  pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id,
           bubble_ex, bubble_mem, halted, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_is_load, ex_rd,
           mc_start, mc_cycles, branch_taken, mem_busy, halt,
    output pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id,
           bubble_ex, bubble_mem, halted, stall_cnt
  );

endinterface

// File: rtl/pipeline_stall_ctrl_hazard.sv
// Load-use detector: a load in EX writing a register the ID instruction reads.
module hazard_detect_unit import pipe_ctrl_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_valid && ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: prioritises halt, memory wait, multi-cycle EX,
// taken branch and load-use, and keeps a saturating stall counter.
module pipeline_stall_ctrl import pipe_ctrl_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MC_CW  = MC_CW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);

  ctrl_state_e      state;
  logic [MC_CW-1:0] mc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             halted_q;
  logic             load_use;
  logic             mc_stall;
  stage_en_t        en;

  hazard_detect_unit #(.REG_AW(REG_AW)) u_hazard (
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_use_rs1 (bus.id_use_rs1),
    .id_use_rs2 (bus.id_use_rs2),
    .ex_valid   (bus.ex_valid),
    .ex_is_load (bus.ex_is_load),
    .ex_rd      (bus.ex_rd),
    .load_use   (load_use)
  );

  // MC_DRAIN deliberately ignores mc_start so the held instruction is not re-triggered
  assign mc_stall = (state == MC_BUSY) ||
                    ((state == RUN) && bus.mc_start && (bus.mc_cycles != '0));

  always_comb begin
    en = en_all();
    if (rst || (state == HALTED) || bus.halt || bus.mem_busy) begin
      en = '0;
    end else if (mc_stall) begin
      en.pc_en      = 1'b0;
      en.en_if_id   = 1'b0;
      en.en_id_ex   = 1'b0;
      en.bubble_mem = 1'b1;
    end else if (bus.branch_taken && (state == RUN)) begin
      en.flush_if_id = 1'b1;
      en.bubble_ex   = 1'b1;
    end else if (load_use) begin
      en.pc_en     = 1'b0;
      en.en_if_id  = 1'b0;
      en.bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      mc_cnt    <= '0;
      stall_cnt <= '0;
      halted_q  <= 1'b0;
    end else begin
      if (!en.pc_en && (state != HALTED) && !bus.halt && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);

      if (bus.halt) begin
        state    <= HALTED;
        halted_q <= 1'b1;
      end else if (!bus.mem_busy) begin
        case (state)
          RUN: begin
            if (bus.mc_start && (bus.mc_cycles == MC_CW'(1))) begin
              state <= MC_DRAIN;
            end else if (bus.mc_start && (bus.mc_cycles != '0)) begin
              state  <= MC_BUSY;
              mc_cnt <= bus.mc_cycles - MC_CW'(1);
            end
          end
          MC_BUSY: begin
            mc_cnt <= mc_cnt - MC_CW'(1);
            if (mc_cnt == MC_CW'(1))
              state <= MC_DRAIN;
          end
          MC_DRAIN: state <= RUN;
          HALTED:   state <= HALTED;
          default:  state <= RUN;
        endcase
      end
    end
  end

  assign bus.pc_en       = en.pc_en;
  assign bus.en_if_id    = en.en_if_id;
  assign bus.en_id_ex    = en.en_id_ex;
  assign bus.en_ex_mem   = en.en_ex_mem;
  assign bus.en_mem_wb   = en.en_mem_wb;
  assign bus.flush_if_id = en.flush_if_id;
  assign bus.bubble_ex   = en.bubble_ex;
  assign bus.bubble_mem  = en.bubble_mem;
  assign bus.halted      = halted_q;
  assign bus.stall_cnt   = stall_cnt;

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush controller for the 5-stage 16-bit pipeline (IF, ID, EX, MEM, WB). It drives the `enable` inputs of the clock-gated stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It also drives the bubble and flush controls that squash instructions. It resolves these events in priority order: halt, memory wait, multi-cycle EX operations, taken branches and load-use hazards. A saturating stall counter is kept for performance debug.

## Interface
- `REG_AW`, 3: register-index width (8 architectural registers, r0 hardwired zero).
- `MC_CW`, 4: width of multi-cycle latency field.
- `CNT_W`, 16: stall counter width.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` in REG_AW: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction reads rs1 / rs2.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_is_load` in 1: the EX instruction is a load.
- `ex_rd` in REG_AW: destination register of the EX instruction.
- `mc_start` in 1: the EX instruction is multi-cycle (stays high while it sits in EX).
- `mc_cycles` in MC_CW: extra EX cycles required by that instruction (0 means single-cycle).
- `branch_taken` in 1: a taken branch or jump resolved in EX.
- `mem_busy` in 1: data memory wait.
- `halt` in 1: a HALT instruction retiring in WB.
- `pc_en`, `en_if_id`, `en_id_ex`, `en_ex_mem`, `en_mem_wb` out 1 each: stage-register enables.
- `flush_if_id` out 1: load a NOP into IF/ID.
- `bubble_ex` out 1: zero the control fields captured into ID/EX.
- `bubble_mem` out 1: zero the control fields captured into EX/MEM.
- `halted` out 1: the core is halted.
- `stall_cnt` out CNT_W: saturating count of stalled cycles.

## Operation
- FSM states:
  - RUN
  - MC_BUSY, with down-counter `mc_cnt` of width MC_CW
  - MC_DRAIN
  - HALTED
- Default outputs, used when no condition is active: all enables 1; flush and bubbles 0.
- Conditions are evaluated every cycle. The first matching condition wins:
  1. HALTED state, or `halt`=1: all enables 0.
  2. `mem_busy`=1: all enables 0. The FSM and `mc_cnt` hold.
  3. A multi-cycle stall is active:
     - pc_en, en_if_id, en_id_ex = 0.
     - en_ex_mem = 1 with bubble_mem = 1.
     - en_mem_wb = 1.
     - A multi-cycle stall is active in MC_BUSY, or in RUN when `mc_start` is high with `mc_cycles` ≠ 0.
  4. `branch_taken`=1 (RUN state only): flush_if_id=1 and bubble_ex=1; all enables 1.
  5. Load-use hazard:
     - The hazard is `ex_valid & ex_is_load & ex_rd≠0`, together with (`id_use_rs1 & id_rs1==ex_rd`) or (`id_use_rs2 & id_rs2==ex_rd`).
     - Response: pc_en=0, en_if_id=0, bubble_ex=1; all other enables 1.
- FSM transitions (none occur while `mem_busy`=1 or in HALTED):
  - RUN, with `mc_start` and N=`mc_cycles`≥1:
    - N=1 → MC_DRAIN.
    - N≥2 → MC_BUSY with mc_cnt=N−1.
  - MC_BUSY: mc_cnt decrements each cycle; when mc_cnt==1 → MC_DRAIN.
  - MC_DRAIN: no stall and `mc_start` ignored, so the operation advances; → RUN.
  - Any state, `halt`=1 → HALTED. HALTED is left only through `rst`.
- Net effect: a multi-cycle instruction causes exactly N stall cycles and is never re-triggered while it is held in EX.
- `stall_cnt` increments when pc_en=0 and the block is neither halted nor halting. It saturates at all-ones and never wraps.

## Timing
- All outputs are combinational from registered state and current inputs (zero latency); state updates on the rising edge of `clk`.
- While `rst`=1:
  - All enables, flush_if_id and both bubbles are 0.
  - On the first edge the registers reset: state=RUN, mc_cnt=0, stall_cnt=0, halted=0.
- Reset mid-stall: on the next edge the block is in RUN with the counter cleared; no residual stall.
- `mem_busy` during MC_BUSY extends the stall one cycle per busy cycle, with no counter decrement.
- `halt` coincident with any other condition: halt wins. `halted` rises the cycle after `halt` is sampled.
- Branch and load-use in the same cycle: branch wins (the ID instruction is wrong-path).

## Structure
- Package `pipe_ctrl_pkg`:
  - `ctrl_state_e` enum (RUN, MC_BUSY, MC_DRAIN, HALTED).
  - `stage_en_t` struct (five enables plus flush and bubbles).
  - REG_AW, MC_CW defaults.
- Sub-module `hazard_detect_unit`: purely combinational load-use compare producing `load_use`. All FSM, priority and counter logic stay in `pipeline_stall_ctrl`.

## Test plan
- Load r3 in EX, ID reads rs2=r3 → exactly one cycle of pc_en=0, en_if_id=0, bubble_ex=1; ex_rd=0 with id_rs2=0 → no stall.
- mc_start, mc_cycles=4 → four cycles of pc_en=0 with bubble_mem=1, then one MC_DRAIN cycle with all enables 1, then RUN; stall_cnt=4.
- mc_cycles=3 with mem_busy high for 2 cycles mid-stall → 5 total frozen cycles; the counter resumes correctly.
- branch_taken with a simultaneous load-use hazard → flush_if_id=1, bubble_ex=1, pc_en=1.
- halt pulse → all enables 0 permanently and halted=1 next cycle; only rst clears it.
- Force 65 535 stall cycles, then further stalls → stall_cnt stays 16'hFFFF; rst mid-MC_BUSY → RUN with all outputs at defaults after release.
